experiment3_dual_ram_engine: RTL and testbench
==============================================

EXPERIMENT3_DUAL_RAM_ENGINE -- requirements
Module: experiment3_dual_ram_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the RAM word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 9, meaning the RAM address width.
REQ-003 SHALL have parameter DEPTH, default 512, meaning the maximum words per pass; legal range is 1..2^ADDR_W.
REQ-004 SHALL have one clock and an asynchronous, active-low reset, as listed in REQ-005 and REQ-006.
REQ-005 CLOCK_50_I  input  1  sole clock; all state is updated on its rising edge.
REQ-006 resetn  input  1  asynchronous active-low reset.
REQ-007 start_i  input  1  start request; sampled only in S_IDLE.
REQ-008 mode_i  input  2  operation select; latched when a start is accepted.
REQ-009 length_i  input  ADDR_W+1  number of words to process; latched when a start is accepted.
REQ-010 rd_data0_i / rd_data1_i  input  DATA_W each  read-port q of RAM0 / RAM1; 1-cycle read latency.
REQ-011 rd_addr_o  output  ADDR_W  shared read address for both RAMs, registered.
REQ-012 wr_addr_o  output  ADDR_W  shared write address for both RAMs, registered.
REQ-013 wr_data0_o / wr_data1_o  output  DATA_W each  write data for RAM0 / RAM1, combinational from rd_data*_i.
REQ-014 wr_en0_o / wr_en1_o  output  1 each  write enables for RAM0 / RAM1, registered; the two are always equal.
REQ-015 busy_o  output  1  high in S_READ_WRITE and S_LAST_WRITE.
REQ-016 done_o  output  1  one-cycle completion pulse, registered.
REQ-017 sat_o  output  1  sticky flag; set by any clamp in mode 01.

Function
REQ-018 FSM states SHALL be S_IDLE, S_READ_WRITE and S_LAST_WRITE.
REQ-019 In S_IDLE, start_i=1 with a clamped length L>0 SHALL latch mode and L, clear sat_o, set rd_addr_o=0, and go to S_READ_WRITE.
REQ-020 length_i > DEPTH SHALL be clamped to DEPTH at latch time.
REQ-021 In S_IDLE, start_i=1 with length_i=0 SHALL make no transition and produce no writes, and SHALL pulse done_o on the next cycle.
REQ-022 Each cycle in S_READ_WRITE SHALL apply: rd_addr_o <= rd_addr_o+1; wr_addr_o <= rd_addr_o; wr_en*_o <= 1.
REQ-023 When rd_addr_o == L-1 in S_READ_WRITE, the next state SHALL be S_LAST_WRITE.
REQ-024 S_LAST_WRITE SHALL apply: rd_addr_o <= 0; wr_addr_o <= 0; wr_en*_o <= 0; done_o <= 1; next state S_IDLE.
REQ-025 wr_en*_o SHALL be high for exactly L consecutive cycles, covering write addresses 0..L-1 in order, each written exactly once.
REQ-026 Latency: with start accepted at cycle 0, first write at cycle 2, last write at cycle L+1, done_o=1 at cycle L+2, and a new start may be accepted at cycle L+2.
REQ-027 The write data for address k SHALL be computed from the rd_data*_i returned by the read of address k issued one cycle earlier.
REQ-028 With a = rd_data0_i and b = rd_data1_i:
- mode 00: wr_data0 = (a+b) mod 2^DATA_W; wr_data1 = (a-b) mod 2^DATA_W.
- mode 01: unsigned saturating; wr_data0 = min(a+b, 2^DATA_W-1); wr_data1 = max(a-b, 0).
- mode 10: wr_data0 = max(a,b); wr_data1 = min(a,b).
- mode 11: wr_data0 = b; wr_data1 = a (swap).
REQ-029 In mode 01, sat_o SHALL set on any write cycle where either result clamped, and SHALL hold until the next accepted start or reset.
REQ-030 start_i and changes on mode_i or length_i SHALL be ignored while busy_o=1.
REQ-031 done_o SHALL be high for exactly one cycle per accepted start.

Reset
REQ-032 resetn=0 SHALL immediately force state S_IDLE and set rd_addr_o, wr_addr_o, wr_en*_o, done_o, sat_o, the latched mode and the latched L to 0.
REQ-033 Reset asserted mid-pass SHALL stop the pass, with no further writes and no done_o pulse.
REQ-034 Outputs SHALL hold their reset values until the first accepted start after resetn returns to 1.

Verification
REQ-035 DATA_W=8, L=512, mode 00, RAM0[k]=k, RAM1[k]=1 -> RAM0[k]=(k+1)&255, RAM1[k]=(k-1)&255; done_o at cycle 514.
REQ-036 Mode 01 with a=200, b=100 at address 3 -> wr_data0=255, wr_data1=100, sat_o=1; a=10, b=20 -> wr_data1=0.
REQ-037 length_i=0 -> zero write-enable cycles and done_o pulse one cycle later; length_i=600 -> exactly 512 writes.
REQ-038 Start with L=4, mode 11, and start_i held high with mode_i toggling during busy -> exactly 4 swapped writes and exactly one done_o.
REQ-039 resetn pulsed low at cycle 100 of a 512-word pass -> wr_en*_o=0 immediately, no done_o, and addresses >=98 unchanged.
REQ-040 Back-to-back starts with start_i asserted at the done_o cycle -> second pass begins with no lost or duplicated writes.

Source files
------------

// File: rtl/experiment3_dual_ram_engine_if.sv
// Bus bundle for the dual-RAM engine: start/mode/length request, RAM read data in,
// shared RAM addresses, write data/enables and status out.
interface experiment3_dual_ram_engine_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 9
);
    logic              start_i;
    logic [1:0]        mode_i;
    logic [ADDR_W:0]   length_i;
    logic [DATA_W-1:0] rd_data0_i;
    logic [DATA_W-1:0] rd_data1_i;
    logic [ADDR_W-1:0] rd_addr_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic [DATA_W-1:0] wr_data0_o;
    logic [DATA_W-1:0] wr_data1_o;
    logic              wr_en0_o;
    logic              wr_en1_o;
    logic              busy_o;
    logic              done_o;
    logic              sat_o;

    modport master (
        output start_i, mode_i, length_i, rd_data0_i, rd_data1_i,
        input  rd_addr_o, wr_addr_o, wr_data0_o, wr_data1_o,
        input  wr_en0_o, wr_en1_o, busy_o, done_o, sat_o
    );

    modport slave (
        input  start_i, mode_i, length_i, rd_data0_i, rd_data1_i,
        output rd_addr_o, wr_addr_o, wr_data0_o, wr_data1_o,
        output wr_en0_o, wr_en1_o, busy_o, done_o, sat_o
    );
endinterface

// File: rtl/experiment3_dual_ram_engine.sv
// Streams L words from two RAMs through a mode-selected ALU and writes the results back
// in place; the write address trails the read address by one cycle of RAM latency.
module experiment3_dual_ram_engine #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 512
) (
    input  logic CLOCK_50_I,
    input  logic resetn,
    experiment3_dual_ram_engine_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_READ_WRITE,
        S_LAST_WRITE
    } state_t;

    localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W+1)'(DEPTH);

    state_t            r_state;
    logic [1:0]        r_mode;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] r_wr_addr;
    logic              r_wr_en;
    logic              r_busy;
    logic              r_done;
    logic              r_sat;

    logic [ADDR_W:0]   w_len_clamp;
    logic [ADDR_W:0]   w_last_idx;
    logic              w_at_last;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_diff;
    logic              w_borrow;
    logic              w_clamp;
    logic [DATA_W-1:0] w_res0;
    logic [DATA_W-1:0] w_res1;

    assign w_len_clamp = (bus.length_i > L_DEPTH) ? L_DEPTH : bus.length_i;
    assign w_last_idx  = r_len - (ADDR_W+1)'(1);
    assign w_at_last   = ({1'b0, r_rd_addr} == w_last_idx);

    assign w_sum    = {1'b0, bus.rd_data0_i} + {1'b0, bus.rd_data1_i};
    assign w_diff   = bus.rd_data0_i - bus.rd_data1_i;
    assign w_borrow = (bus.rd_data0_i < bus.rd_data1_i);
    assign w_clamp  = w_sum[DATA_W] | w_borrow;

    always_comb begin
        w_res0 = w_sum[DATA_W-1:0];
        w_res1 = w_diff;
        case (r_mode)
            2'b00: begin
                w_res0 = w_sum[DATA_W-1:0];
                w_res1 = w_diff;
            end
            2'b01: begin
                w_res0 = w_sum[DATA_W] ? '1 : w_sum[DATA_W-1:0];
                w_res1 = w_borrow ? '0 : w_diff;
            end
            2'b10: begin
                w_res0 = w_borrow ? bus.rd_data1_i : bus.rd_data0_i;
                w_res1 = w_borrow ? bus.rd_data0_i : bus.rd_data1_i;
            end
            default: begin
                w_res0 = bus.rd_data1_i;
                w_res1 = bus.rd_data0_i;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50_I or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_mode    <= '0;
            r_len     <= '0;
            r_rd_addr <= '0;
            r_wr_addr <= '0;
            r_wr_en   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_sat     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // Clamp detection covers every committed write, including the one in S_LAST_WRITE.
            if (r_wr_en && (r_mode == 2'b01) && w_clamp) begin
                r_sat <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        if (w_len_clamp != '0) begin
                            r_mode    <= bus.mode_i;
                            r_len     <= w_len_clamp;
                            r_sat     <= 1'b0;
                            r_rd_addr <= '0;
                            r_busy    <= 1'b1;
                            r_state   <= S_READ_WRITE;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                end
                S_READ_WRITE: begin
                    r_rd_addr <= r_rd_addr + ADDR_W'(1);
                    r_wr_addr <= r_rd_addr;
                    r_wr_en   <= 1'b1;
                    if (w_at_last) begin
                        r_state <= S_LAST_WRITE;
                    end
                end
                S_LAST_WRITE: begin
                    r_rd_addr <= '0;
                    r_wr_addr <= '0;
                    r_wr_en   <= 1'b0;
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.rd_addr_o  = r_rd_addr;
    assign bus.wr_addr_o  = r_wr_addr;
    assign bus.wr_data0_o = w_res0;
    assign bus.wr_data1_o = w_res1;
    assign bus.wr_en0_o   = r_wr_en;
    assign bus.wr_en1_o   = r_wr_en;
    assign bus.busy_o     = r_busy;
    assign bus.done_o     = r_done;
    assign bus.sat_o      = r_sat;
endmodule

// File: tb/tb_experiment3_dual_ram_engine.sv
// Bench for experiment3_dual_ram_engine: two behavioural RAMs around the DUT, and an
// array-level reference model of each pass compared against final RAM contents and timing.
module tb_experiment3_dual_ram_engine;
    localparam int DW    = 8;
    localparam int AW    = 9;
    localparam int DEPTH = 512;
    localparam int MAXV  = (1 << DW) - 1;
    localparam int LOGN  = 8192;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    experiment3_dual_ram_engine_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    experiment3_dual_ram_engine #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .CLOCK_50_I (clk),
        .resetn     (resetn),
        .bus        (bus)
    );

    // RAM models and write/done monitors
    logic [DW-1:0] ram0 [0:DEPTH-1];
    logic [DW-1:0] ram1 [0:DEPTH-1];
    logic [DW-1:0] init0 [0:DEPTH-1];
    logic [DW-1:0] init1 [0:DEPTH-1];
    logic [DW-1:0] q0, q1;
    logic          load;
    int            wr_cnt = 0;
    int            done_cnt = 0;
    int            en_diff = 0;
    int            wlog [0:LOGN-1];

    assign bus.rd_data0_i = q0;
    assign bus.rd_data1_i = q1;

    always @(posedge clk) begin
        if (load) begin
            ram0 <= init0;
            ram1 <= init1;
        end else begin
            if (bus.wr_en0_o) ram0[bus.wr_addr_o] <= bus.wr_data0_o;
            if (bus.wr_en1_o) ram1[bus.wr_addr_o] <= bus.wr_data1_o;
        end
        if (bus.wr_en0_o) begin
            wlog[wr_cnt % LOGN] <= int'(bus.wr_addr_o);
            wr_cnt <= wr_cnt + 1;
        end
        if (bus.wr_en0_o !== bus.wr_en1_o) en_diff <= en_diff + 1;
        if (bus.done_o) done_cnt <= done_cnt + 1;
        q0 <= ram0[bus.rd_addr_o];
        q1 <= ram1[bus.rd_addr_o];
    end

    // Reference state
    int n_vec = 0;
    int n_bad = 0;
    int cur0 [0:DEPTH-1];
    int cur1 [0:DEPTH-1];
    int exp0 [0:DEPTH-1];
    int exp1 [0:DEPTH-1];
    bit exp_sat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic void ref_op(input logic [1:0] m, input int a, input int b,
                                   output int r0, output int r1, output bit clamp);
        clamp = 1'b0;
        case (m)
            2'd0: begin r0 = (a + b) % (MAXV + 1); r1 = (a - b + MAXV + 1) % (MAXV + 1); end
            2'd1: begin
                r0 = (a + b > MAXV) ? MAXV : a + b;
                r1 = (a < b) ? 0 : a - b;
                clamp = (a + b > MAXV) || (a < b);
            end
            2'd2: begin r0 = (a > b) ? a : b; r1 = (a < b) ? a : b; end
            default: begin r0 = b; r1 = a; end
        endcase
    endfunction

    // Model of a pass over the first n words of cur, n already clamped
    task automatic model_pass(input logic [1:0] m, input int n);
        int r0, r1;
        bit cl, any;
        any = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin exp0[i] = cur0[i]; exp1[i] = cur1[i]; end
        for (int i = 0; i < n; i++) begin
            ref_op(m, cur0[i], cur1[i], r0, r1, cl);
            exp0[i] = r0;
            exp1[i] = r1;
            if (m == 2'd1 && cl) any = 1'b1;
        end
        exp_sat = any;
    endtask

    task automatic load_cur();
        for (int i = 0; i < DEPTH; i++) begin init0[i] = cur0[i][DW-1:0]; init1[i] = cur1[i][DW-1:0]; end
        @(negedge clk); load = 1'b1;
        @(negedge clk); load = 1'b0;
    endtask

    task automatic fill_rand(input bit nosat);
        for (int i = 0; i < DEPTH; i++) begin
            cur0[i] = nosat ? int'($urandom_range(0, MAXV / 2)) : int'($urandom_range(0, MAXV));
            cur1[i] = nosat ? int'($urandom_range(0, cur0[i])) : int'($urandom_range(0, MAXV));
        end
    endtask

    task automatic cmp_ram(input string tag);
        int b0, b1;
        b0 = 0; b1 = 0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ram0[i] !== exp0[i][DW-1:0]) b0++;
            if (ram1[i] !== exp1[i][DW-1:0]) b1++;
        end
        chk({tag, ".ram0_bad_words"}, b0, 0);
        chk({tag, ".ram1_bad_words"}, b1, 0);
    endtask

    task automatic do_pass(input string tag, input logic [1:0] m, input int len, input bit pre,
                           input bit toggle, input bit chain, input logic [1:0] nm, input int nl);
        int lc, k, wb, db, ob;
        bit prev_sat;
        lc = (len > DEPTH) ? DEPTH : len;
        prev_sat = exp_sat;
        model_pass(m, lc);
        if (lc == 0) exp_sat = prev_sat;
        if (!pre) begin
            @(negedge clk);
            bus.start_i  = 1'b1;
            bus.mode_i   = m;
            bus.length_i = len[AW:0];
        end
        @(posedge clk); #1;
        wb = wr_cnt; db = done_cnt;
        k = 0;
        while (k < lc + 20) begin
            @(negedge clk);
            k++;
            if (toggle) begin
                bus.mode_i   = 2'($urandom);
                bus.length_i = (AW+1)'($urandom);
            end else begin
                bus.start_i = 1'b0;
            end
            if (bus.done_o === 1'b1) break;
        end
        if (chain) begin
            bus.start_i = 1'b1; bus.mode_i = nm; bus.length_i = nl[AW:0];
        end else begin
            bus.start_i = 1'b0;
        end
        chk({tag, ".done_latency"}, k, (lc > 0) ? lc + 2 : 1);
        chk({tag, ".write_count"}, wr_cnt - wb, lc);
        ob = 0;
        for (int i = 0; i < lc; i++) if (wlog[(wb + i) % LOGN] != i) ob++;
        chk({tag, ".addr_order_bad"}, ob, 0);
        cmp_ram(tag);
        chk({tag, ".sat"}, bus.sat_o, exp_sat);
        chk({tag, ".busy_at_done"}, bus.busy_o, 1'b0);
        chk({tag, ".wr_en_pair_diff"}, en_diff, 0);
        if (!chain) begin
            repeat (4) @(negedge clk);
            chk({tag, ".done_pulses"}, done_cnt - db, 1);
            chk({tag, ".writes_after"}, wr_cnt - wb, lc);
        end
        for (int i = 0; i < DEPTH; i++) begin cur0[i] = exp0[i]; cur1[i] = exp1[i]; end
    endtask

    initial begin
        int wb, db;
        logic [1:0] rm;
        bus.start_i = 1'b0; bus.mode_i = 2'b00; bus.length_i = '0;
        load = 1'b0; exp_sat = 1'b0;
        resetn = 1'b1;
        #2 resetn = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset.rd_addr", bus.rd_addr_o, 0);
        chk("reset.wr_addr", bus.wr_addr_o, 0);
        chk("reset.wr_en0", bus.wr_en0_o, 0);
        chk("reset.wr_en1", bus.wr_en1_o, 0);
        chk("reset.busy", bus.busy_o, 0);
        chk("reset.done", bus.done_o, 0);
        chk("reset.sat", bus.sat_o, 0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_reset.wr_en0", bus.wr_en0_o, 0);

        // Full-depth add/sub with RAM0[k]=k, RAM1[k]=1
        for (int i = 0; i < DEPTH; i++) begin cur0[i] = i & MAXV; cur1[i] = 1; end
        load_cur();
        do_pass("full_add", 2'd0, 512, 0, 0, 0, 2'd0, 0);

        // Saturating mode with known clamp points, then a zero-length start holds sat
        fill_rand(1'b1);
        cur0[3] = 200; cur1[3] = 100; cur0[4] = 10; cur1[4] = 20;
        load_cur();
        do_pass("sat_dir", 2'd1, 8, 0, 0, 0, 2'd0, 0);
        chk("sat_dir.addr3_ram0", ram0[3], 255);
        chk("sat_dir.addr3_ram1", ram1[3], 100);
        chk("sat_dir.addr4_ram1", ram1[4], 0);
        do_pass("zero_len", 2'd2, 0, 0, 0, 0, 2'd0, 0);

        // Saturating mode with no clamp clears sat on the new start
        fill_rand(1'b1);
        load_cur();
        do_pass("sat_none", 2'd1, 33, 0, 0, 0, 2'd0, 0);

        // Oversize length clamps to DEPTH
        fill_rand(1'b0);
        load_cur();
        do_pass("len600", 2'd2, 600, 0, 0, 0, 2'd0, 0);

        // start held and inputs toggling while busy
        do_pass("hold_swap", 2'd3, 4, 0, 1, 0, 2'd0, 0);

        // Boundary single-word pass, then back-to-back chained passes
        do_pass("len1", 2'd0, 1, 0, 0, 0, 2'd0, 0);
        do_pass("chain_a", 2'd2, 5, 0, 0, 1, 2'd3, 7);
        do_pass("chain_b", 2'd3, 7, 1, 0, 0, 2'd0, 0);

        // Randomized passes
        for (int p = 0; p < 6; p++) begin
            fill_rand(1'b0);
            load_cur();
            rm = 2'($urandom);
            do_pass($sformatf("rand%0d", p), rm, int'($urandom_range(1, 40)), 0, 0, 0, 2'd0, 0);
        end

        // Reset in the middle of a full-depth pass
        fill_rand(1'b0);
        load_cur();
        @(negedge clk);
        bus.start_i = 1'b1; bus.mode_i = 2'd0; bus.length_i = (AW+1)'(512);
        @(posedge clk); #1;
        wb = wr_cnt; db = done_cnt;
        repeat (100) begin @(negedge clk); bus.start_i = 1'b0; end
        resetn = 1'b0;
        #1;
        chk("midreset.wr_en0", bus.wr_en0_o, 0);
        chk("midreset.wr_en1", bus.wr_en1_o, 0);
        chk("midreset.busy", bus.busy_o, 0);
        chk("midreset.rd_addr", bus.rd_addr_o, 0);
        model_pass(2'd0, 98);
        exp_sat = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (8) @(negedge clk);
        chk("midreset.writes", wr_cnt - wb, 98);
        chk("midreset.done_pulses", done_cnt - db, 0);
        chk("midreset.hold_wr_addr", bus.wr_addr_o, 0);
        chk("midreset.hold_sat", bus.sat_o, 0);
        cmp_ram("midreset");
        for (int i = 0; i < DEPTH; i++) begin cur0[i] = exp0[i]; cur1[i] = exp1[i]; end

        // Engine still works after the interrupted pass
        do_pass("after_reset", 2'd1, 17, 0, 0, 0, 2'd0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
